// File: rtl/wb_arb2_if.sv
// wb_arb2_if
//  Bundle of every bus signal around the two-master Wishbone arbiter: the
//  instruction-fetch master (m0_*), the load/store master (m1_*) and the
//  shared on-chip RAM slave (s_*). Suffixes _i/_o are seen from the arbiter.
//  Modports:
//   master - arbiter view; it is the single bus master of the RAM segment,
//            takes both CPU requests in and drives the slave side out.
//   slave  - environment view (CPU masters plus RAM), the mirror image.
interface wb_arb2_if #(
   parameter int AW = 32
);
   logic          m0_cyc_i;
   logic          m0_stb_i;
   logic          m0_we_i;
   logic [3:0]    m0_sel_i;
   logic [AW-1:0] m0_adr_i;
   logic [31:0]   m0_dat_i;
   logic [31:0]   m0_dat_o;
   logic          m0_ack_o;
   logic          m0_err_o;

   logic          m1_cyc_i;
   logic          m1_stb_i;
   logic          m1_we_i;
   logic [3:0]    m1_sel_i;
   logic [AW-1:0] m1_adr_i;
   logic [31:0]   m1_dat_i;
   logic [31:0]   m1_dat_o;
   logic          m1_ack_o;
   logic          m1_err_o;

   logic          s_cyc_o;
   logic          s_stb_o;
   logic          s_we_o;
   logic [3:0]    s_sel_o;
   logic [AW-1:0] s_adr_o;
   logic [31:0]   s_dat_o;
   logic [31:0]   s_dat_i;
   logic          s_ack_i;

   modport master (
      input  m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
      output m0_dat_o, m0_ack_o, m0_err_o,
      input  m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
      output m1_dat_o, m1_ack_o, m1_err_o,
      output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
      input  s_dat_i, s_ack_i
   );

   modport slave (
      output m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i,
      input  m0_dat_o, m0_ack_o, m0_err_o,
      output m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i,
      input  m1_dat_o, m1_ack_o, m1_err_o,
      input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o,
      output s_dat_i, s_ack_i
   );
endinterface

// File: rtl/wb_arb2.sv
// wb_arb2
//  Two-master / one-slave Wishbone classic arbiter in front of the on-chip RAM.
//  M0 is CPU instruction fetch, M1 is CPU load/store. One master is granted at
//  a time (round robin on simultaneous requests, M0 first after reset), its
//  cycle is muxed onto the slave and ack is routed back only to it. A watchdog
//  ends a strobe that sees no ack for TIMEOUT cycles with a one-cycle err.
//  Ports:
//   wb_clk_i  clock, all state on the rising edge
//   wb_rst_i  synchronous active-high reset
//   bus       wb_arb2_if.master: m0_*, m1_* request sides and s_* slave side
//  Parameters:
//   AW        address width of masters and slave
//   TIMEOUT   strobe cycles without ack before err (>= 2)
module wb_arb2 #(
   parameter int AW      = 32,
   parameter int TIMEOUT = 255
) (
   input  logic      wb_clk_i,
   input  logic      wb_rst_i,
   wb_arb2_if.master bus
);
   localparam int              WD_W    = 16;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } state_t;

   state_t          state;
   logic            last_gnt;
   logic [WD_W-1:0] wd_cnt;
   logic            gnt0;
   logic            gnt1;
   logic            stb_sel;
   logic            wd_hit;

   assign gnt0 = (state == GNT0);
   assign gnt1 = (state == GNT1);

   // Grant FSM. A releasing master hands straight over to a waiting one, so
   // back-to-back traffic from alternating masters never sees an IDLE bubble.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.m0_cyc_i && (!bus.m1_cyc_i || last_gnt)) begin
                  state    <= GNT0;
                  last_gnt <= 1'b0;
               end else if (bus.m1_cyc_i) begin
                  state    <= GNT1;
                  last_gnt <= 1'b1;
               end
            end
            GNT0: begin
               if (!bus.m0_cyc_i) begin
                  if (bus.m1_cyc_i) begin
                     state    <= GNT1;
                     last_gnt <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            GNT1: begin
               if (!bus.m1_cyc_i) begin
                  if (bus.m0_cyc_i) begin
                     state    <= GNT0;
                     last_gnt <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Watchdog: counts strobe cycles without ack. The terminal cycle drops
   // s_stb_o, which clears the count, so a held strobe simply restarts it.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i || !bus.s_stb_o || bus.s_ack_i) begin
         wd_cnt <= '0;
      end else begin
         wd_cnt <= wd_cnt + 1'b1;
      end
   end

   // A real ack in the terminal cycle wins: no err and the strobe stays up.
   assign wd_hit = stb_sel && !bus.s_ack_i && (wd_cnt == WD_LAST);

   // Slave side is a pure mux of the granted master; IDLE drives all zeros.
   always_comb begin
      bus.s_cyc_o = 1'b0;
      bus.s_we_o  = 1'b0;
      bus.s_sel_o = 4'b0;
      bus.s_adr_o = {AW{1'b0}};
      bus.s_dat_o = 32'b0;
      stb_sel     = 1'b0;
      case (state)
         GNT0: begin
            bus.s_cyc_o = bus.m0_cyc_i;
            bus.s_we_o  = bus.m0_we_i;
            bus.s_sel_o = bus.m0_sel_i;
            bus.s_adr_o = bus.m0_adr_i;
            bus.s_dat_o = bus.m0_dat_i;
            stb_sel     = bus.m0_stb_i;
         end
         GNT1: begin
            bus.s_cyc_o = bus.m1_cyc_i;
            bus.s_we_o  = bus.m1_we_i;
            bus.s_sel_o = bus.m1_sel_i;
            bus.s_adr_o = bus.m1_adr_i;
            bus.s_dat_o = bus.m1_dat_i;
            stb_sel     = bus.m1_stb_i;
         end
         default: ;
      endcase
   end

   assign bus.s_stb_o = stb_sel && !wd_hit;

   // Ack is qualified by the master's own strobe so an ack arriving after the
   // master has dropped its cycle is discarded rather than misrouted.
   assign bus.m0_ack_o = bus.s_ack_i && gnt0 && bus.m0_stb_i;
   assign bus.m1_ack_o = bus.s_ack_i && gnt1 && bus.m1_stb_i;
   assign bus.m0_err_o = wd_hit && gnt0;
   assign bus.m1_err_o = wd_hit && gnt1;
   assign bus.m0_dat_o = bus.s_dat_i;
   assign bus.m1_dat_o = bus.s_dat_i;
endmodule
